// File: rtl/alu_pkg.sv
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the execute-stage arithmetic blocks
//            (ALU, multiplier, sequential divider).
// Contents : XLEN operand width, sequential-unit state encoding,
//            signed most-negative constant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

  localparam int XLEN = 64;

  // Shared by the multi-cycle units: idle, iterating, result held.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } alu_seq_state_e;

  localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

endpackage

`default_nettype wire

// File: rtl/subtractor_64bit.sv
// ============================================================================
// Module   : subtractor_64bit
// Purpose  : Fixed-width 64-bit subtractor, diff = a - b - c_in.
// Ports    : a, b     - operands
//            c_in     - borrow in
//            diff     - difference (mod 2^64)
//            c_out    - borrow out (1 when a < b + c_in, unsigned)
//            overflow - two's-complement overflow of the subtraction
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module subtractor_64bit
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            c_in,
  output logic [XLEN-1:0] diff,
  output logic            c_out,
  output logic            overflow
);

  logic [XLEN:0] w_full;

  assign w_full   = {1'b0, a} - {1'b0, b} - {{XLEN{1'b0}}, c_in};
  assign diff     = w_full[XLEN-1:0];
  assign c_out    = w_full[XLEN];
  // Operands of differing sign whose result sign differs from a.
  assign overflow = (a[XLEN-1] ^ b[XLEN-1]) & (diff[XLEN-1] ^ a[XLEN-1]);

endmodule

`default_nettype wire

// File: rtl/seq_divider_64bit.sv
// ============================================================================
// Module   : seq_divider_64bit
// Purpose  : Multi-cycle restoring divider, one quotient bit per cycle,
//            signed or unsigned, valid/ready on both sides.
// Ports    : clk, rst_n (sync, active low), flush (sync squash)
//            in_valid/in_ready, dividend, divisor, is_signed  - operand side
//            out_valid/out_ready, quotient, remainder,
//            div_by_zero                                    - result side
// Notes    : WIDTH must be 64 (trial subtractor is fixed-width).
//            Special cases (x/0, MIN/-1) spend a single CALC cycle and
//            skip the iterations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider_64bit
  import alu_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             is_signed,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [6:0]       LAST = 7'(WIDTH - 1);

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + ONE;
  endfunction

  alu_seq_state_e   state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;       // partial remainder
  logic [WIDTH-1:0] dq_q, dq_d;     // dividend bits shift out, quotient bits in
  logic [WIDTH-1:0] dvs_q, dvs_d;   // |divisor|
  logic [6:0]       cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             spec_q, spec_d; // special-case result parked in dq_q/r_q
  logic             dbzp_q, dbzp_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] w_s, w_diff, w_rnext, w_qnext;
  logic [WIDTH-1:0] w_dvd_abs, w_dvs_abs;
  logic             w_c, w_succ, w_div_zero, w_ovf_case;
  logic             w_sub_borrow, w_sub_ovf;
  logic             w_unused;

  // Shifted remainder; its dropped MSB acts as a 65th bit of S.
  assign w_s = {r_q[WIDTH-2:0], dq_q[WIDTH-1]};
  assign w_c = r_q[WIDTH-1];

  subtractor_64bit u_sub (
    .a        (w_s),
    .b        (dvs_q),
    .c_in     (1'b0),
    .diff     (w_diff),
    .c_out    (w_sub_borrow),
    .overflow (w_sub_ovf)
  );

  // The subtractor flags are not needed: the decision uses the 65-bit compare.
  assign w_unused = w_sub_borrow ^ w_sub_ovf;

  assign w_succ  = w_c | (w_s >= dvs_q);
  assign w_rnext = w_succ ? w_diff : w_s;
  assign w_qnext = {dq_q[WIDTH-2:0], w_succ};

  assign w_dvd_abs  = (is_signed & dividend[WIDTH-1]) ? negate(dividend) : dividend;
  assign w_dvs_abs  = (is_signed & divisor[WIDTH-1])  ? negate(divisor)  : divisor;
  assign w_div_zero = (divisor == '0);
  assign w_ovf_case = is_signed & (dividend == SIGNED_MIN) & (divisor == '1);

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    spec_d  = spec_q;
    dbzp_d  = dbzp_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_CALC;
          cnt_d   = '0;
          dvs_d   = w_dvs_abs;
          if (w_div_zero) begin
            spec_d = 1'b1;
            dbzp_d = 1'b1;
            dq_d   = '1;
            r_d    = dividend;
            qneg_d = 1'b0;
            rneg_d = 1'b0;
          end else if (w_ovf_case) begin
            spec_d = 1'b1;
            dbzp_d = 1'b0;
            dq_d   = dividend;
            r_d    = '0;
            qneg_d = 1'b0;
            rneg_d = 1'b0;
          end else begin
            spec_d = 1'b0;
            dbzp_d = 1'b0;
            dq_d   = w_dvd_abs;
            r_d    = '0;
            qneg_d = is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg_d = is_signed & dividend[WIDTH-1];
          end
        end
      end

      ST_CALC: begin
        if (spec_q) begin
          state_d = ST_DONE;
          quot_d  = dq_q;
          rem_d   = r_q;
          dbz_d   = dbzp_q;
        end else begin
          r_d   = w_rnext;
          dq_d  = w_qnext;
          cnt_d = cnt_q + 7'd1;
          if (cnt_q == LAST) begin
            state_d = ST_DONE;
            quot_d  = qneg_q ? negate(w_qnext) : w_qnext;
            rem_d   = rneg_q ? negate(w_rnext) : w_rnext;
            dbz_d   = 1'b0;
          end
        end
      end

      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // Squash wins over any handshake and never publishes a partial result.
    if (flush) begin
      state_d = ST_IDLE;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      spec_q  <= 1'b0;
      dbzp_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      spec_q  <= spec_d;
      dbzp_q  <= dbzp_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

`default_nettype wire
